// File: rtl/d_mem.sv
// d_mem: 4096x32 little-endian data memory with byte/half/word access and a registered, extended load port
module d_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        rden,
  input  logic        wen,
  input  logic [1:0]  byte_sel,
  input  logic        sign,
  input  logic [13:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);
  logic [31:0] ram_64kb [0:4095];
  logic [11:0] idx;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] word;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ld;
  // Lane enables and replicated store data force halfword/word alignment; load data is picked and extended from the pre-write word
  always_comb begin
    idx   = addr[13:2];
    be    = byte_sel == 2'b00 ? 4'b0001 << addr[1:0] :
            byte_sel == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = byte_sel == 2'b00 ? {4{data_in[7:0]}} :
            byte_sel == 2'b01 ? {2{data_in[15:0]}} : data_in;
    word  = ram_64kb[idx];
    bsel  = word[{addr[1:0], 3'b000} +: 8];
    hsel  = word[{addr[1], 4'b0000} +: 16];
    ld    = byte_sel == 2'b00 ? {{24{sign & bsel[7]}}, bsel} :
            byte_sel == 2'b01 ? {{16{sign & hsel[15]}}, hsel} : word;
  end
  // Storage is never reset; stores are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (!rst && wen)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram_64kb[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  // Load register clears asynchronously and otherwise holds unless a load is sampled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out <= 32'h0;
    else if (rden) data_out <= ld;
  end
endmodule

// File: tb/tb_d_mem.sv
// tb_d_mem: randomized and directed checks of d_mem against a byte-array reference model
module tb_d_mem;
  logic        clk = 0;
  logic        rst = 1;
  logic        rden = 0;
  logic        wen = 0;
  logic [1:0]  byte_sel = 0;
  logic        sign = 0;
  logic [13:0] addr = 0;
  logic [31:0] data_in = 0;
  logic [31:0] data_out;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  mem [0:16383];
  logic [31:0] exp_out = 0;

  d_mem dut (
    .clk(clk), .rst(rst), .rden(rden), .wen(wen), .byte_sel(byte_sel),
    .sign(sign), .addr(addr), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] bs, input logic sg, input int a);
    int b;
    logic [31:0] v;
    if (bs == 2'b00) begin
      v = {24'h0, mem[a]};
      if (sg && mem[a][7]) v = v | 32'hFFFF_FF00;
    end else if (bs == 2'b01) begin
      b = a - (a % 2);
      v = {16'h0, mem[b+1], mem[b]};
      if (sg && mem[b+1][7]) v = v | 32'hFFFF_0000;
    end else begin
      b = a - (a % 4);
      v = {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    end
    return v;
  endfunction

  task automatic model_store(input logic [1:0] bs, input int a, input logic [31:0] d);
    int b;
    int n;
    n = bs == 2'b00 ? 1 : bs == 2'b01 ? 2 : 4;
    b = a - (a % n);
    for (int k = 0; k < n; k++) mem[b+k] = d[8*k +: 8];
  endtask

  task automatic op(input string tag, input logic r, input logic w, input logic [1:0] bs,
                    input logic sg, input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    rden = r; wen = w; byte_sel = bs; sign = sg; addr = a; data_in = d;
    if (r) exp_out = model_load(bs, sg, int'(a));
    if (w) model_store(bs, int'(a), d);
    @(posedge clk);
    #1;
    check(tag, data_out, exp_out);
    rden = 0; wen = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) dut.ram_64kb[i] = 32'h0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h0;
    #12;
    check("reset_out", data_out, 32'h0);
    @(negedge clk) rst = 0;
    op("st_w0", 0, 1, 2'b10, 0, 14'd0, 32'hDEADBEE0);
    op("ld_w0", 1, 0, 2'b10, 0, 14'd0, 32'h0);
    check("ld_w0_const", data_out, 32'hDEADBEE0);
    op("st_b4", 0, 1, 2'b00, 0, 14'd4, 32'hDEADBEE4);
    op("ld_w4a", 1, 0, 2'b10, 0, 14'd4, 32'h0);
    check("ld_w4a_const", data_out, 32'h0000_00E4);
    op("st_b6", 0, 1, 2'b00, 0, 14'd6, 32'h0000_00A5);
    op("ld_sb6", 1, 0, 2'b00, 1, 14'd6, 32'h0);
    check("ld_sb6_const", data_out, 32'hFFFF_FFA5);
    op("ld_w4b", 1, 0, 2'b10, 0, 14'd4, 32'h0);
    check("ld_w4b_const", data_out, 32'h00A5_00E4);
    op("st_h8", 0, 1, 2'b01, 0, 14'd8, 32'hDEADBEE8);
    op("ld_w8", 1, 0, 2'b10, 0, 14'd8, 32'h0);
    check("ld_w8_const", data_out, 32'h0000_BEE8);
    op("ld_sh8", 1, 0, 2'b01, 1, 14'd8, 32'h0);
    check("ld_sh8_const", data_out, 32'hFFFF_BEE8);
    op("ld_uh8", 1, 0, 2'b01, 0, 14'd8, 32'h0);
    check("ld_uh8_const", data_out, 32'h0000_BEE8);
    op("st_w1", 0, 1, 2'b10, 0, 14'd1, 32'hDEADBEEF);
    check("ram0_dump", dut.ram_64kb[0], 32'hDEADBEEF);
    op("ld_w1", 1, 0, 2'b10, 0, 14'd1, 32'h0);
    check("ld_w1_const", data_out, 32'hDEADBEEF);
    op("st_w3_sel3", 0, 1, 2'b11, 0, 14'd3, 32'h1111_1111);
    op("rbw", 1, 1, 2'b10, 0, 14'd0, 32'h2222_2222);
    check("rbw_const", data_out, 32'h1111_1111);
    op("rbw_next", 1, 0, 2'b10, 0, 14'd0, 32'h0);
    check("rbw_next_const", data_out, 32'h2222_2222);
    op("st_w100", 0, 1, 2'b10, 0, 14'd100, 32'hCAFE_F00D);
    op("hold", 0, 0, 2'b10, 0, 14'd100, 32'h0);
    #3 rst = 1;
    #1 check("rst_async", data_out, 32'h0);
    exp_out = 0;
    @(negedge clk) rst = 0;
    op("ld_after_rst", 1, 0, 2'b10, 0, 14'd100, 32'h0);
    check("ld_after_rst_const", data_out, 32'hCAFE_F00D);
    op("ld_pre", 1, 0, 2'b10, 0, 14'd0, 32'h0);
    @(negedge clk);
    rden = 1; wen = 1; byte_sel = 2'b10; addr = 14'd100; data_in = 32'h5555_5555;
    #3 rst = 1;
    @(posedge clk);
    #1 check("rst_discard", data_out, 32'h0);
    exp_out = 0;
    rden = 0; wen = 0;
    @(negedge clk) rst = 0;
    op("rst_no_store", 1, 0, 2'b10, 0, 14'd100, 32'h0);
    for (int i = 0; i < 600; i++) begin
      logic [13:0] a;
      a = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 47));
      op("rand", 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end
    for (int i = 0; i < 48; i += 4) op("sweep", 1, 0, 2'b10, 0, 14'(i), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
